// File: rtl/uart_tx_port.sv
// Store-driven 8N1 UART transmitter with a small FIFO and a pollable status byte.
// Writes to TX_ADDR queue a byte. Writes to STAT_ADDR clear the sticky overflow flag.
module uart_tx_port #(
    parameter int          CLK_HZ     = 50000000,
    parameter int          BAUD       = 115200,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [7:0]  TX_ADDR    = 8'hFE,
    parameter logic [7:0]  STAT_ADDR  = 8'hFF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          we,
    input  logic [7:0]                    address,
    input  logic [7:0]                    data,
    output logic                          txd,
    output logic                          busy,
    output logic                          fifo_empty,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic [7:0]                    status
);

    localparam int DIV = CLK_HZ / BAUD;
    localparam int DW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;

    state_t          state, state_n;
    logic [7:0]      sh, sh_n;
    logic [2:0]      bitcnt, bitcnt_n;
    logic [DW-1:0]   divcnt, divcnt_n;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wptr, rptr;
    logic            push, pop, drop, clr, bit_end;

    assign push       = we && (address == TX_ADDR) && !fifo_full;
    assign drop       = we && (address == TX_ADDR) && fifo_full;
    assign clr        = we && (address == STAT_ADDR);
    assign fifo_empty = (count == CW'(0));
    assign fifo_full  = (count == CW'(FIFO_DEPTH));
    assign busy       = (state != IDLE);
    assign status     = {4'b0000, overflow, fifo_full, fifo_empty, busy};
    assign bit_end    = (divcnt == DW'(DIV - 1));

    // FIFO storage; contents need no reset because count guards every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= data;
        end else begin
            mem[wptr] <= mem[wptr];
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag (set beats clear)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr     <= PW'(0);
            rptr     <= PW'(0);
            count    <= CW'(0);
            overflow <= 1'b0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr) begin
                overflow <= 1'b0;
            end else begin
                overflow <= overflow;
            end
        end
    end

    // Transmit state register; txd is decoded from the current state so it lags one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            sh     <= 8'h00;
            bitcnt <= 3'd0;
            divcnt <= DW'(0);
            txd    <= 1'b1;
        end else begin
            state  <= state_n;
            sh     <= sh_n;
            bitcnt <= bitcnt_n;
            divcnt <= divcnt_n;
            case (state)
                START:   txd <= 1'b0;
                DATA:    txd <= sh[0];
                default: txd <= 1'b1;
            endcase
        end
    end

    // Next-state logic; STOP reloads straight into START so frames run back to back
    always_comb begin
        state_n  = state;
        sh_n     = sh;
        bitcnt_n = bitcnt;
        divcnt_n = divcnt;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                divcnt_n = DW'(0);
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    sh_n     = mem[rptr];
                    bitcnt_n = 3'd0;
                    state_n  = START;
                end else begin
                    state_n  = IDLE;
                end
            end
            START: begin
                if (bit_end) begin
                    divcnt_n = DW'(0);
                    state_n  = DATA;
                end else begin
                    divcnt_n = divcnt + DW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    divcnt_n = DW'(0);
                    sh_n     = {1'b0, sh[7:1]};
                    bitcnt_n = bitcnt + 3'd1;
                    if (bitcnt == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        state_n = DATA;
                    end
                end else begin
                    divcnt_n = divcnt + DW'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    divcnt_n = DW'(0);
                    if (!fifo_empty) begin
                        pop      = 1'b1;
                        sh_n     = mem[rptr];
                        bitcnt_n = 3'd0;
                        state_n  = START;
                    end else begin
                        state_n  = IDLE;
                    end
                end else begin
                    divcnt_n = divcnt + DW'(1);
                end
            end
            default: begin
                state_n  = IDLE;
                divcnt_n = DW'(0);
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_port.sv
// Directed bench for uart_tx_port with DIV=4: line waveform, FIFO status, overflow and reset abort.
module tb_uart_tx_port;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       we = 1'b0;
    logic [7:0] address = 8'h00;
    logic [7:0] data = 8'h00;
    logic       txd, busy, fifo_empty, fifo_full, overflow;
    logic [2:0] count;
    logic [7:0] status;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         t0 = 0;
    int         nfr = 0;
    logic       track = 1'b0;
    logic [7:0] eb [5];

    uart_tx_port #(
        .CLK_HZ(16), .BAUD(4), .FIFO_DEPTH(4), .TX_ADDR(8'hFE), .STAT_ADDR(8'hFF)
    ) dut (
        .clk(clk), .rst(rst), .we(we), .address(address), .data(data),
        .txd(txd), .busy(busy), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
        .count(count), .overflow(overflow), .status(status)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line level r edges after the first store: frames of 40 cycles starting at r=2
    function automatic logic exp_txd(input int r);
        int f, k;
        if (r < 2) return 1'b1;
        f = (r - 2) / 40;
        if (f >= nfr) return 1'b1;
        k = ((r - 2) % 40) / 4;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return eb[f][k-1];
    endfunction

    task automatic tick();
        int r;
        @(posedge clk);
        #1;
        cyc++;
        if (track) begin
            r = cyc - t0;
            chk("txd", {31'd0, txd}, {31'd0, exp_txd(r)});
            chk("busy", {31'd0, busy}, (r >= 1 && r <= 40 * nfr) ? 32'd1 : 32'd0);
        end
    endtask

    task automatic store(input logic [7:0] a, input logic [7:0] d);
        we = 1'b1;
        address = a;
        data = d;
        tick();
        we = 1'b0;
        address = 8'h00;
        data = 8'h00;
    endtask

    initial begin
        rst = 1'b1;
        #1;
        chk("reset_txd", {31'd0, txd}, 32'd1);
        chk("reset_status", {24'd0, status}, 32'h02);
        repeat (3) tick();
        rst = 1'b0;
        repeat (20) begin
            tick();
            chk("idle_txd", {31'd0, txd}, 32'd1);
            chk("idle_status", {24'd0, status}, 32'h02);
            chk("idle_count", {29'd0, count}, 32'd0);
        end

        // single frame of 8'hA5
        eb[0] = 8'hA5;
        nfr = 1;
        t0 = cyc + 1;
        track = 1'b1;
        store(8'hFE, 8'hA5);
        chk("single_count_push", {29'd0, count}, 32'd1);
        tick();
        chk("single_count_pop", {29'd0, count}, 32'd0);
        tick();
        chk("single_start", {31'd0, txd}, 32'd0);
        repeat (45) tick();
        chk("single_end_status", {24'd0, status}, 32'h02);
        track = 1'b0;

        // burst of five bytes, then a dropped store, a clear, and an unmapped store
        for (int i = 0; i < 5; i++) eb[i] = 8'(i + 1);
        nfr = 5;
        t0 = cyc + 1;
        track = 1'b1;
        store(8'hFE, 8'h01);
        chk("burst_count1", {29'd0, count}, 32'd1);
        store(8'hFE, 8'h02);
        chk("burst_count2", {29'd0, count}, 32'd1);
        store(8'hFE, 8'h03);
        chk("burst_count3", {29'd0, count}, 32'd2);
        store(8'hFE, 8'h04);
        chk("burst_count4", {29'd0, count}, 32'd3);
        store(8'hFE, 8'h05);
        chk("burst_count5", {29'd0, count}, 32'd4);
        chk("burst_full", {31'd0, fifo_full}, 32'd1);
        chk("burst_no_ovf", {31'd0, overflow}, 32'd0);
        store(8'hFE, 8'h77);
        chk("drop_ovf", {31'd0, overflow}, 32'd1);
        chk("drop_count", {29'd0, count}, 32'd4);
        chk("drop_status", {24'd0, status}, 32'h0D);
        store(8'hFF, 8'h00);
        chk("clear_ovf", {31'd0, overflow}, 32'd0);
        store(8'h10, 8'h55);
        chk("other_addr_count", {29'd0, count}, 32'd4);
        chk("other_addr_status", {24'd0, status}, 32'h05);
        while (cyc - t0 < 210) tick();
        chk("burst_end_status", {24'd0, status}, 32'h02);
        track = 1'b0;

        // reset in the middle of the first data bit
        eb[0] = 8'h3C;
        eb[1] = 8'h5A;
        nfr = 2;
        t0 = cyc + 1;
        track = 1'b1;
        store(8'hFE, 8'h3C);
        store(8'hFE, 8'h5A);
        while (cyc - t0 < 7) tick();
        chk("pre_rst_txd", {31'd0, txd}, 32'd0);
        chk("pre_rst_count", {29'd0, count}, 32'd1);
        track = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_txd", {31'd0, txd}, 32'd1);
        chk("rst_count", {29'd0, count}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        tick();
        rst = 1'b0;
        repeat (30) begin
            tick();
            chk("post_rst_txd", {31'd0, txd}, 32'd1);
            chk("post_rst_busy", {31'd0, busy}, 32'd0);
            chk("post_rst_count", {29'd0, count}, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
